mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 47 ++++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Memory-stage request, data-bus request/response and completion signals for mem_access_ctrl.
// master = pipeline/bus side, slave = the controller.
interface mem_access_ctrl_if;
    // memory-stage request
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [63:0] req_addr;
    logic [2:0]  req_msize;
    logic        req_unsigned;
    logic [63:0] req_wd;
    logic [7:0]  req_strobe;

    // data-bus request
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;

    // data-bus response
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    // pipeline status and result
    logic        stall;
    logic        done;
    logic [63:0] rdata;
    logic        misalign;

    modport master (
        output req_valid, req_read, req_write, req_addr, req_msize,
        output req_unsigned, req_wd, req_strobe,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  stall, done, rdata, misalign
    );

    modport slave (
        input  req_valid, req_read, req_write, req_addr, req_msize,
        input  req_unsigned, req_wd, req_strobe,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output stall, done, rdata, misalign
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one data-bus transaction per instruction, load alignment/extension.
// Latency: accept -> done in 2 cycles minimum (1 for a misaligned access); done is a one-cycle pulse.
// Backpressure: dreq held stable until dresp_addr_ok; stall freezes upstream from accept until the DONE cycle.
module mem_access_ctrl (
    input  logic             clk,
    input  logic             resetn,
    mem_access_ctrl_if.slave bus
);

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      state;

    logic        dreq_valid_q;
    logic [63:0] addr_q;
    logic [2:0]  size_q;
    logic [7:0]  strobe_q;
    logic [63:0] data_q;
    logic        write_q;
    logic        unsigned_q;
    logic        done_q;
    logic        misalign_q;
    logic [63:0] rdata_q;

    logic        accept;
    logic        misaligned;
    logic [63:0] load_value;

    // Shift the addressed lanes down to bit 0, then narrow and extend to 64 bits.
    function automatic logic [63:0] load_extend(
        input logic [63:0] data,
        input logic [2:0]  offset,
        input logic [2:0]  size,
        input logic        is_unsigned
    );
        logic [63:0] shifted;
        logic [63:0] result;
        shifted = data >> {offset, 3'b000};
        case (size)
            MSIZE1:  result = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
            MSIZE2:  result = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            MSIZE4:  result = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_msize)
            MSIZE2:  misaligned = bus.req_addr[0];
            MSIZE4:  misaligned = |bus.req_addr[1:0];
            MSIZE8:  misaligned = |bus.req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // A request with neither read nor write is a pass-through and is never accepted.
    assign accept     = (state == IDLE) & bus.req_valid & (bus.req_read | bus.req_write);
    assign load_value = load_extend(bus.dresp_data, addr_q[2:0], size_q, unsigned_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            dreq_valid_q <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            strobe_q     <= '0;
            data_q       <= '0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            done_q       <= 1'b0;
            misalign_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= bus.req_addr;
                        size_q     <= bus.req_msize;
                        data_q     <= bus.req_wd;
                        // read+write together is treated as a store
                        write_q    <= bus.req_write;
                        strobe_q   <= bus.req_write ? bus.req_strobe : 8'h00;
                        unsigned_q <= bus.req_unsigned;
                        misalign_q <= misaligned;
                        if (misaligned) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state        <= REQ;
                            dreq_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.dresp_addr_ok) begin
                        dreq_valid_q <= 1'b0;
                        if (bus.dresp_data_ok) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            if (!write_q) begin
                                rdata_q <= load_value;
                            end
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (bus.dresp_data_ok) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        if (!write_q) begin
                            rdata_q <= load_value;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // stall must rise in the accept cycle itself, so it cannot be registered.
    assign bus.stall       = accept | (state == REQ) | (state == WAIT_DATA);
    assign bus.done        = done_q;
    assign bus.misalign    = misalign_q;
    assign bus.rdata       = rdata_q;
    assign bus.dreq_valid  = dreq_valid_q;
    assign bus.dreq_addr   = addr_q;
    assign bus.dreq_size   = size_q;
    assign bus.dreq_strobe = strobe_q;
    assign bus.dreq_data   = data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed stimulus for mem_access_ctrl; expected completions are queued at issue and
// checked by an independent monitor whenever dreq_valid or done is presented.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        misal;
        int          lat;
        int          dreq_cyc;
        int          gap;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   last_done_cyc = 0;
    int   dreq_cnt = 0;
    logic prev_stall = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: per-cycle dreq checks and per-completion result checks.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
            dreq_cnt   = 0;
        end else begin
            if (bus.stall && !prev_stall) begin
                acc_cyc  = cyc;
                dreq_cnt = 0;
            end
            prev_stall = bus.stall;
            if (bus.dreq_valid) begin
                dreq_cnt++;
                if (sb.size() == 0) begin
                    flag("unexpected_dreq: dreq_valid high with no access pending");
                end else if (sb[0].misal) begin
                    flag("dreq_on_misaligned: dreq_valid high for a misaligned access");
                end else begin
                    check64("dreq_addr",   bus.dreq_addr,          sb[0].addr);
                    check64("dreq_size",   64'(bus.dreq_size),     64'(sb[0].size));
                    check64("dreq_strobe", 64'(bus.dreq_strobe),   64'(sb[0].strobe));
                    check64("dreq_data",   bus.dreq_data,          sb[0].data);
                end
            end
            if (bus.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    flag("unexpected_done: done with no access pending");
                end else begin
                    mon_e = sb.pop_front();
                    check64("rdata",         bus.rdata,               mon_e.rdata);
                    check64("misalign",      64'(bus.misalign),       64'(mon_e.misal));
                    check64("latency",       64'(cyc - acc_cyc),      64'(mon_e.lat));
                    check64("stall_in_done", 64'(bus.stall),          64'd0);
                    check64("dreq_cycles",   64'(dreq_cnt),           64'(mon_e.dreq_cyc));
                    if (mon_e.gap >= 0) begin
                        check64("done_gap", 64'(cyc - last_done_cyc), 64'(mon_e.gap));
                    end
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid     = 1'b0;
        bus.req_read      = 1'b0;
        bus.req_write     = 1'b0;
        bus.req_addr      = '0;
        bus.req_msize     = '0;
        bus.req_unsigned  = 1'b0;
        bus.req_wd        = '0;
        bus.req_strobe    = '0;
        bus.dresp_addr_ok = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = '0;
    endtask

    function automatic exp_t mk(input logic [63:0] addr, input logic [2:0] sz, input logic wr,
                                input logic [63:0] wd, input logic [7:0] strb, input logic mis,
                                input logic [63:0] rd, input int lat, input int dc, input int gap);
        exp_t e;
        e.addr     = addr;
        e.size     = sz;
        e.strobe   = wr ? strb : 8'h00;
        e.data     = wd;
        e.misal    = mis;
        e.rdata    = rd;
        e.lat      = lat;
        e.dreq_cyc = dc;
        e.gap      = gap;
        return e;
    endfunction

    task automatic wait_done(input int target, input string name);
        int i;
        i = 0;
        while (n_done < target && i < 40) begin
            step();
            i++;
        end
        if (n_done < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: done count %0d, expected %0d", name, n_done, target);
            sb.delete();
        end
    endtask

    // ad = REQ cycles before addr_ok, dd = cycles from addr_ok to data_ok (0 = same cycle)
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [63:0] addr, input logic [2:0] sz, input logic uns,
                              input logic [63:0] wd, input logic [7:0] strb, input logic [63:0] resp,
                              input int ad, input int dd, input logic mis, input logic [63:0] exp_rdata);
        int target;
        target = n_done + 1;
        sb.push_back(mk(addr, sz, wr, wd, strb, mis, exp_rdata,
                        mis ? 1 : 2 + ad + dd, mis ? 0 : ad + 1, -1));
        bus.req_valid    = 1'b1;
        bus.req_read     = rd;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_msize    = sz;
        bus.req_unsigned = uns;
        bus.req_wd       = wd;
        bus.req_strobe   = strb;
        bus.dresp_data   = resp;
        step();
        // scramble the request bus so dreq must come from latched fields
        bus.req_valid  = 1'b0;
        bus.req_read   = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = ~addr;
        bus.req_wd     = ~wd;
        bus.req_strobe = ~strb;
        if (!mis) begin
            repeat (ad) step();
            bus.dresp_addr_ok = 1'b1;
            bus.dresp_data_ok = (dd == 0);
            step();
            bus.dresp_addr_ok = 1'b0;
            bus.dresp_data_ok = 1'b0;
            if (dd > 0) begin
                repeat (dd - 1) step();
                bus.dresp_data_ok = 1'b1;
                step();
                bus.dresp_data_ok = 1'b0;
            end
        end
        wait_done(target, name);
    endtask

    initial begin
        int target;
        int done_before;

        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check64("rst_dreq_valid",  64'(bus.dreq_valid),  64'd0);
        check64("rst_dreq_addr",   bus.dreq_addr,        64'd0);
        check64("rst_dreq_fields", 64'({bus.dreq_size, bus.dreq_strobe}), 64'd0);
        check64("rst_dreq_data",   bus.dreq_data,        64'd0);
        check64("rst_flags",       64'({bus.stall, bus.done, bus.misalign}), 64'd0);
        check64("rst_rdata",       bus.rdata,            64'd0);
        step();
        resetn = 1'b1;
        step();

        run_access("load_byte_signed", 1, 0, 64'h1003, 3'd0, 0, 64'h0, 8'h00,
                   64'h0000_0000_8000_0000, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80);
        run_access("store_word_slow", 0, 1, 64'h2004, 3'd2, 0, 64'hDEAD_BEEF_0000_0000, 8'hF0,
                   64'h1111_2222_3333_4444, 3, 2, 0, 64'hFFFF_FFFF_FFFF_FF80);
        run_access("misaligned_word", 1, 0, 64'h3002, 3'd2, 0, 64'h0, 8'h00,
                   64'h0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FF80);
        run_access("load_half_unsigned", 1, 0, 64'h4006, 3'd1, 1, 64'h0, 8'h00,
                   64'hBEEF_0000_0000_0000, 0, 1, 0, 64'h0000_0000_0000_BEEF);
        run_access("load_word_signed", 1, 0, 64'h5004, 3'd2, 0, 64'h0, 8'h00,
                   64'h8765_4321_0000_0000, 1, 0, 0, 64'hFFFF_FFFF_8765_4321);
        run_access("load_dword_strobe0", 1, 0, 64'h6000, 3'd3, 0, 64'h0, 8'hFF,
                   64'h0123_4567_89AB_CDEF, 0, 0, 0, 64'h0123_4567_89AB_CDEF);
        run_access("rd_wr_is_store", 1, 1, 64'hA000, 3'd3, 0, 64'hCAFE_F00D_1234_5678, 8'hFF,
                   64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 64'h0123_4567_89AB_CDEF);
        run_access("misaligned_dword", 1, 0, 64'h8004, 3'd3, 0, 64'h0, 8'h00,
                   64'h0, 0, 0, 1, 64'h0123_4567_89AB_CDEF);
        run_access("misaligned_half", 0, 1, 64'h9001, 3'd1, 0, 64'h0, 8'h03,
                   64'h0, 0, 0, 1, 64'h0123_4567_89AB_CDEF);
        run_access("load_byte_odd", 1, 0, 64'h9001, 3'd0, 1, 64'h0, 8'h00,
                   64'h0000_0000_0000_AB00, 0, 0, 0, 64'h0000_0000_0000_00AB);

        // pass-through: valid with neither read nor write
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'hD000;
        repeat (3) begin
            @(negedge clk);
            check64("passthru_stall", 64'(bus.stall), 64'd0);
            check64("passthru_done",  64'(bus.done),  64'd0);
        end
        step();
        bus.req_valid = 1'b0;
        step();

        // back-to-back loads with req_valid held
        target = n_done + 2;
        sb.push_back(mk(64'hB000, 3'd3, 0, 64'h0, 8'h00, 0, 64'h1122_3344_5566_7788, 2, 1, -1));
        sb.push_back(mk(64'hB000, 3'd3, 0, 64'h0, 8'h00, 0, 64'h1122_3344_5566_7788, 2, 1, 3));
        bus.req_valid     = 1'b1;
        bus.req_read      = 1'b1;
        bus.req_addr      = 64'hB000;
        bus.req_msize     = 3'd3;
        bus.req_wd        = 64'h0;
        bus.req_strobe    = 8'h00;
        bus.dresp_data    = 64'h1122_3344_5566_7788;
        bus.dresp_addr_ok = 1'b1;
        bus.dresp_data_ok = 1'b1;
        wait_done(target, "back_to_back");
        idle_inputs();
        step();

        // reset while waiting for data, then a stale data_ok after release
        sb.push_back(mk(64'hC000, 3'd3, 0, 64'h0, 8'h00, 0, 64'h0, 0, 0, -1));
        bus.req_valid  = 1'b1;
        bus.req_read   = 1'b1;
        bus.req_addr   = 64'hC000;
        bus.req_msize  = 3'd3;
        bus.dresp_data = 64'h5555_AAAA_5555_AAAA;
        step();
        bus.req_valid     = 1'b0;
        bus.req_read      = 1'b0;
        bus.dresp_addr_ok = 1'b1;
        step();
        bus.dresp_addr_ok = 1'b0;
        step();
        check64("wait_stall", 64'(bus.stall), 64'd1);
        resetn = 1'b0;
        #1;
        check64("midrst_dreq_valid", 64'(bus.dreq_valid), 64'd0);
        check64("midrst_dreq_addr",  bus.dreq_addr,        64'd0);
        check64("midrst_flags",      64'({bus.stall, bus.done, bus.misalign}), 64'd0);
        check64("midrst_rdata",      bus.rdata,            64'd0);
        sb.delete();
        done_before = n_done;
        step();
        resetn = 1'b1;
        step();
        bus.dresp_data_ok = 1'b1;
        step();
        bus.dresp_data_ok = 1'b0;
        repeat (3) step();
        check64("stale_dataok_done", 64'(n_done - done_before), 64'd0);
        check64("stale_dataok_rdata", bus.rdata, 64'd0);
        check64("stale_dataok_stall", 64'(bus.stall), 64'd0);

        run_access("post_reset_byte", 1, 0, 64'h7007, 3'd0, 1, 64'h0, 8'h00,
                   64'hF100_0000_0000_0000, 0, 0, 0, 64'h0000_0000_0000_00F1);

        repeat (3) step();
        check64("leftover_expected", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule
